cavlc_run_before: RTL and testbench

//  H.264 CAVLC run_before encoder for one 4x4 block (16 zig-zag coefficients).

---
 rtl/cavlc_pkg.sv | 95 +++++++++
 rtl/cavlc_run_before_lut.sv | 23 ++
 rtl/cavlc_run_before.sv | 153 +++++++++++++++
 tb/tb_cavlc_run_before.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_pkg
// Desc     : Shared widths, FSM state type and run_before VLC table for the
//            CAVLC run_before encoder.
// Revision : 1.0 - initial release
// ============================================================================
package cavlc_pkg;

   localparam int c_coeff_w    = 15;
   localparam int c_num_coeff  = 16;
   localparam int c_code_w     = 25;
   localparam int c_len_w      = 5;
   localparam int c_vlc_code_w = 11;
   localparam int c_vlc_len_w  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [c_vlc_code_w-1:0] code;
      logic [c_vlc_len_w-1:0]  len;
   } vlc_t;

   // Codes are right-aligned in 'code'; combinations with run > zl cannot occur
   // for consistent block statistics and map to an empty code.
   function automatic vlc_t run_before_vlc(input logic [3:0] run, input logic [3:0] zl);
      vlc_t v;
      v = '0;
      case (zl)
         4'd0: v = '0;
         4'd1: case (run)
                  4'd0:    v = '{11'd1, 4'd1};
                  4'd1:    v = '{11'd0, 4'd1};
                  default: v = '0;
               endcase
         4'd2: case (run)
                  4'd0:    v = '{11'd1, 4'd1};
                  4'd1:    v = '{11'd1, 4'd2};
                  4'd2:    v = '{11'd0, 4'd2};
                  default: v = '0;
               endcase
         4'd3: case (run)
                  4'd0:    v = '{11'd3, 4'd2};
                  4'd1:    v = '{11'd2, 4'd2};
                  4'd2:    v = '{11'd1, 4'd2};
                  4'd3:    v = '{11'd0, 4'd2};
                  default: v = '0;
               endcase
         4'd4: case (run)
                  4'd0:    v = '{11'd3, 4'd2};
                  4'd1:    v = '{11'd2, 4'd2};
                  4'd2:    v = '{11'd1, 4'd2};
                  4'd3:    v = '{11'd1, 4'd3};
                  4'd4:    v = '{11'd0, 4'd3};
                  default: v = '0;
               endcase
         4'd5: case (run)
                  4'd0:    v = '{11'd3, 4'd2};
                  4'd1:    v = '{11'd2, 4'd2};
                  4'd2:    v = '{11'd3, 4'd3};
                  4'd3:    v = '{11'd2, 4'd3};
                  4'd4:    v = '{11'd1, 4'd3};
                  4'd5:    v = '{11'd0, 4'd3};
                  default: v = '0;
               endcase
         4'd6: case (run)
                  4'd0:    v = '{11'd3, 4'd2};
                  4'd1:    v = '{11'd0, 4'd3};
                  4'd2:    v = '{11'd1, 4'd3};
                  4'd3:    v = '{11'd3, 4'd3};
                  4'd4:    v = '{11'd2, 4'd3};
                  4'd5:    v = '{11'd5, 4'd3};
                  4'd6:    v = '{11'd4, 4'd3};
                  default: v = '0;
               endcase
         default: begin
            // zl > 6: 3-bit codes for short runs, then a unary-style escape
            if (run < 4'd7) begin
               v.code = {8'd0, 3'd7 - run[2:0]};
               v.len  = 4'd3;
            end else begin
               v.code = {{(c_vlc_code_w-1){1'b0}}, 1'b1};
               v.len  = run - 4'd3;
            end
         end
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_run_before_lut.sv
`default_nettype none
// ============================================================================
// Module   : run_before_lut
// Desc     : Combinational run_before VLC lookup, (run, zerosLeft) -> code/len.
// Revision : 1.0 - initial release
// ============================================================================
module run_before_lut
   import cavlc_pkg::*;
(
   input  logic [3:0]              run,
   input  logic [3:0]              zl,
   output logic [c_vlc_code_w-1:0] code,
   output logic [c_vlc_len_w-1:0]  len
);

   vlc_t w_vlc;

   assign w_vlc = run_before_vlc(run, zl);
   assign code  = w_vlc.code;
   assign len   = w_vlc.len;

endmodule
`default_nettype wire

// File: rtl/cavlc_run_before.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_run_before
// Desc     : H.264 CAVLC run_before encoder for one 4x4 block; scans down from
//            the last nonzero coefficient and packs all codes MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module cavlc_run_before
   import cavlc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [3:0]           RightmostCoeff_index,
   input  logic [3:0]           totalcoeff,
   input  logic [3:0]           totalzero,
   input  logic [c_coeff_w-1:0] din_00,
   input  logic [c_coeff_w-1:0] din_01,
   input  logic [c_coeff_w-1:0] din_02,
   input  logic [c_coeff_w-1:0] din_03,
   input  logic [c_coeff_w-1:0] din_04,
   input  logic [c_coeff_w-1:0] din_05,
   input  logic [c_coeff_w-1:0] din_06,
   input  logic [c_coeff_w-1:0] din_07,
   input  logic [c_coeff_w-1:0] din_08,
   input  logic [c_coeff_w-1:0] din_09,
   input  logic [c_coeff_w-1:0] din_10,
   input  logic [c_coeff_w-1:0] din_11,
   input  logic [c_coeff_w-1:0] din_12,
   input  logic [c_coeff_w-1:0] din_13,
   input  logic [c_coeff_w-1:0] din_14,
   input  logic [c_coeff_w-1:0] din_15,
   output logic                 finish,
   output logic [c_len_w-1:0]   CodeLength,
   output logic [c_code_w-1:0]  CodeBit
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [c_num_coeff-1:0]  r_flags;
   logic [3:0]              r_cur;
   logic [3:0]              r_zl;
   logic [3:0]              r_left;
   logic [3:0]              r_run;
   logic [c_code_w-1:0]     r_code_bit;
   logic [c_len_w-1:0]      r_code_len;

   logic [c_num_coeff-1:0]  w_flags;
   logic                    w_skip;
   logic                    w_hit;
   logic [3:0]              w_zl_nxt;
   logic [3:0]              w_left_nxt;
   logic                    w_scan_end;
   logic [c_vlc_code_w-1:0] w_code;
   logic [c_vlc_len_w-1:0]  w_len;

   assign w_flags = {din_15 != '0, din_14 != '0, din_13 != '0, din_12 != '0,
                     din_11 != '0, din_10 != '0, din_09 != '0, din_08 != '0,
                     din_07 != '0, din_06 != '0, din_05 != '0, din_04 != '0,
                     din_03 != '0, din_02 != '0, din_01 != '0, din_00 != '0};

   // Blocks with no zeros, fewer than two coefficients or a single position emit nothing.
   assign w_skip = (totalzero == 4'd0) || (totalcoeff <= 4'd1) ||
                   (RightmostCoeff_index == 4'd0);

   assign w_hit      = r_flags[r_cur];
   assign w_zl_nxt   = w_hit ? (r_zl - r_run) : r_zl;
   assign w_left_nxt = w_hit ? (r_left - 4'd1) : r_left;
   // Position 0 also terminates so inconsistent statistics cannot wrap the scan.
   assign w_scan_end = (w_zl_nxt == 4'd0) || (w_left_nxt == 4'd0) || (r_cur == 4'd0);

   run_before_lut u_lut (
      .run  (r_run),
      .zl   (r_zl),
      .code (w_code),
      .len  (w_len)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      finish      = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_state_nxt = w_skip ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (w_scan_end) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            finish      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flags    <= '0;
         r_cur      <= '0;
         r_zl       <= '0;
         r_left     <= '0;
         r_run      <= '0;
         r_code_bit <= '0;
         r_code_len <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_flags    <= w_flags;
                  r_cur      <= RightmostCoeff_index - 4'd1;
                  r_zl       <= totalzero;
                  r_left     <= totalcoeff - 4'd1;
                  r_run      <= '0;
                  r_code_bit <= '0;
                  r_code_len <= '0;
               end
            end
            SCAN: begin
               if (w_hit) begin
                  r_code_bit <= (r_code_bit << w_len) |
                                {{(c_code_w-c_vlc_code_w){1'b0}}, w_code};
                  r_code_len <= r_code_len + {1'b0, w_len};
                  r_zl       <= w_zl_nxt;
                  r_left     <= w_left_nxt;
                  r_run      <= '0;
               end else begin
                  r_run      <= r_run + 4'd1;
               end
               r_cur <= r_cur - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign CodeBit    = r_code_bit;
   assign CodeLength = r_code_len;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_run_before.sv
`default_nettype none
// ============================================================================
// Module   : tb_cavlc_run_before
// Desc     : Self-checking bench for cavlc_run_before against a string-based
//            run_before reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cavlc_run_before;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [3:0]  idx_i;
   logic [3:0]  tc_i;
   logic [3:0]  tz_i;
   logic [14:0] din [16];
   logic        finish;
   logic [4:0]  CodeLength;
   logic [24:0] CodeBit;

   int          checks   = 0;
   int          errors   = 0;
   int          done_cnt = 0;
   bit          exp_valid   = 1'b0;
   bit          prev_finish = 1'b0;
   logic [24:0] exp_bit = '0;
   logic [4:0]  exp_len = '0;

   always #5 clk = ~clk;

   cavlc_run_before dut (
      .clk                  (clk),
      .rst                  (rst),
      .enable               (enable),
      .RightmostCoeff_index (idx_i),
      .totalcoeff           (tc_i),
      .totalzero            (tz_i),
      .din_00 (din[0]),  .din_01 (din[1]),  .din_02 (din[2]),  .din_03 (din[3]),
      .din_04 (din[4]),  .din_05 (din[5]),  .din_06 (din[6]),  .din_07 (din[7]),
      .din_08 (din[8]),  .din_09 (din[9]),  .din_10 (din[10]), .din_11 (din[11]),
      .din_12 (din[12]), .din_13 (din[13]), .din_14 (din[14]), .din_15 (din[15]),
      .finish               (finish),
      .CodeLength           (CodeLength),
      .CodeBit              (CodeBit)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // run_before code words as bit strings, straight from the standard's table
   function automatic string vlc(input int run, input int zl);
      string r = "";
      case (zl)
         1: case (run) 0: r = "1";  1: r = "0"; default: r = ""; endcase
         2: case (run) 0: r = "1";  1: r = "01"; 2: r = "00"; default: r = ""; endcase
         3: case (run) 0: r = "11"; 1: r = "10"; 2: r = "01"; 3: r = "00"; default: r = ""; endcase
         4: case (run) 0: r = "11"; 1: r = "10"; 2: r = "01"; 3: r = "001"; 4: r = "000";
                       default: r = ""; endcase
         5: case (run) 0: r = "11"; 1: r = "10"; 2: r = "011"; 3: r = "010"; 4: r = "001";
                       5: r = "000"; default: r = ""; endcase
         6: case (run) 0: r = "11"; 1: r = "000"; 2: r = "001"; 3: r = "011"; 4: r = "010";
                       5: r = "101"; 6: r = "100"; default: r = ""; endcase
         default: case (run)
            0: r = "111"; 1: r = "110"; 2: r = "101"; 3: r = "100";
            4: r = "011"; 5: r = "010"; 6: r = "001";
            default: begin
               for (int i = 0; i < run - 4; i++) r = {r, "0"};
               r = {r, "1"};
            end
         endcase
      endcase
      return r;
   endfunction

   // Walk the nonzero positions from the top; each gap is the run before that coefficient.
   function automatic string model_str(input int idx);
      int    pos[$];
      int    zl;
      int    run;
      string s = "";
      for (int i = idx; i >= 0; i--) if (din[i] != '0) pos.push_back(i);
      zl = idx + 1 - pos.size();
      for (int k = 0; k + 1 < pos.size() && zl > 0; k++) begin
         run = pos[k] - pos[k+1] - 1;
         s   = {s, vlc(run, zl)};
         zl -= run;
      end
      return s;
   endfunction

   task automatic set_expect(input string s);
      exp_bit = '0;
      for (int i = 0; i < s.len(); i++) exp_bit = {exp_bit[23:0], s.getc(i) == 8'h31};
      exp_len = 5'(s.len());
   endtask

   task automatic load(input int v[16], input int idx, input int tc, input int tz);
      for (int i = 0; i < 16; i++) din[i] = 15'(v[i]);
      idx_i = 4'(idx);
      tc_i  = 4'(tc);
      tz_i  = 4'(tz);
   endtask

   task automatic gen_random();
      int idx;
      int dens;
      int cnt;
      idx  = int'($urandom_range(15, 0));
      dens = int'($urandom_range(100, 0));
      for (int i = 0; i < 16; i++) begin
         if (i > idx) din[i] = '0;
         else if (i == idx || int'($urandom_range(99, 0)) < dens)
            din[i] = 15'($urandom_range(32767, 1));
         else din[i] = '0;
      end
      cnt = 0;
      for (int i = 0; i < 16; i++) if (din[i] != '0) cnt++;
      if (cnt == 16) begin
         din[$urandom_range(14, 0)] = '0;
         cnt = 15;
      end
      idx_i = 4'(idx);
      tc_i  = 4'(cnt);
      tz_i  = 4'(idx + 1 - cnt);
   endtask

   task automatic pin(input string name, input int lit_len, input logic [24:0] lit_bit);
      set_expect(model_str(int'(idx_i)));
      chk({name, "_model_len"}, 32'(exp_len), 32'(lit_len));
      chk({name, "_model_bit"}, 32'(exp_bit), 32'(lit_bit));
   endtask

   task automatic wait_done(input string name, input int bound, input int base, input int drop_k);
      bit got = 1'b0;
      for (int k = 1; k <= bound; k++) begin
         @(negedge clk);
         #1;
         if (k == drop_k) enable = 1'b0;
         if (done_cnt != base) begin
            got = 1'b1;
            break;
         end
      end
      chk({name, "_finish_seen"}, 32'(got), 32'd1);
   endtask

   task automatic run_case(input string name, input int bound, input bit hold);
      int base;
      set_expect(model_str(int'(idx_i)));
      @(negedge clk);
      exp_valid = 1'b1;
      enable    = 1'b1;
      base      = done_cnt;
      wait_done(name, bound, base, hold ? 0 : 1);
      if (hold) begin
         base = done_cnt;
         wait_done({name, "_restart"}, bound + 2, base, 2);
      end
      enable    = 1'b0;
      exp_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk({name, "_hold_bit"}, 32'(CodeBit), 32'(exp_bit));
      chk({name, "_hold_len"}, 32'(CodeLength), 32'(exp_len));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         prev_finish = 1'b0;
      end else begin
         if (finish) begin
            done_cnt++;
            chk("finish_expected", 32'(exp_valid), 32'(finish));
            chk("finish_one_cycle", 32'(prev_finish), 32'd0);
            if (exp_valid) begin
               chk("CodeBit", 32'(CodeBit), 32'(exp_bit));
               chk("CodeLength", 32'(CodeLength), 32'(exp_len));
            end
         end
         prev_finish = finish;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst    = 1'b0;
      enable = 1'b0;
      idx_i  = '0;
      tc_i   = '0;
      tz_i   = '0;
      for (int i = 0; i < 16; i++) din[i] = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_finish", 32'(finish), 32'd0);
      chk("reset_len", 32'(CodeLength), 32'd0);
      chk("reset_bit", 32'(CodeBit), 32'd0);
      rst = 1'b1;

      load('{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}, 7, 5, 3);
      pin("case1", 6, 25'b101101);
      run_case("case1", 9, 1'b1);

      load('{3, 0, 61, 20, 0, 8, 0, 56, 0, 0, 52, 1, 50, 46, 0, 0}, 13, 9, 5);
      pin("case2", 15, 25'b111111011100110);
      run_case("case2", 15, 1'b0);

      load('{-2, 4, 3, -3, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 6, 5, 2);
      pin("case3", 2, 25'b00);
      run_case("case3", 8, 1'b0);

      load('{-1, 4, 3, -3, 1, 1, -1, 1, 0, 0, 0, 0, 0, 0, 0, 0}, 7, 8, 0);
      pin("case4", 0, 25'd0);
      run_case("case4", 2, 1'b0);

      load('{5, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8}, 15, 9, 7);
      pin("case5", 25, 25'h1FFFFF1);
      run_case("case5", 17, 1'b0);

      // Abort case 2 mid-scan, then rerun it
      load('{3, 0, 61, 20, 0, 8, 0, 56, 0, 0, 52, 1, 50, 46, 0, 0}, 13, 9, 5);
      set_expect(model_str(13));
      @(negedge clk);
      exp_valid = 1'b1;
      enable    = 1'b1;
      base      = done_cnt;
      @(negedge clk);
      #1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst       = 1'b0;
      exp_valid = 1'b0;
      #1;
      chk("abort_bit", 32'(CodeBit), 32'd0);
      chk("abort_len", 32'(CodeLength), 32'd0);
      chk("abort_finish", 32'(finish), 32'd0);
      chk("abort_no_early_finish", 32'(done_cnt), 32'(base));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("abort_no_finish_after", 32'(done_cnt), 32'(base));
      run_case("case2_rerun", 15, 1'b0);

      for (int n = 0; n < 300; n++) begin
         gen_random();
         run_case("random", int'(idx_i) + 2, $urandom_range(9, 0) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
